// File: rtl/pd_pkg.sv
// pd_pkg: default geometry and saturation constant shared by the power-detect blocks
package pd_pkg;
    localparam int ANT_NUM_D = 4;
    localparam int ANW_D     = 2;
    localparam int SANW_D    = 5;
    localparam int DW_D      = 16;
    localparam int ACCW_D    = 48;
    localparam logic [ACCW_D-1:0] ACC_SAT_D = '1;
endpackage

// File: rtl/pd_pwr.sv
// pd_pwr: two-stage I^2+Q^2 power pipeline with antenna/valid delay line
module pd_pwr
    import pd_pkg::*;
#(
    parameter int ANW = ANW_D,
    parameter int DW  = DW_D
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 valid,
    input  logic [ANW-1:0]       ant,
    input  logic signed [DW-1:0] data_i,
    input  logic signed [DW-1:0] data_q,
    output logic                 pwr_valid,
    output logic [ANW-1:0]       pwr_ant,
    output logic [2*DW-1:0]      pwr
);
    logic signed [2*DW-1:0] ii, qq;
    logic                   v1;
    logic [ANW-1:0]         a1;

    // squares in stage 1, their sum in stage 2; tags ride alongside
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            v1        <= 1'b0;
            a1        <= '0;
            ii        <= '0;
            qq        <= '0;
            pwr_valid <= 1'b0;
            pwr_ant   <= '0;
            pwr       <= '0;
        end else begin
            v1        <= valid;
            a1        <= ant;
            ii        <= (2*DW)'(data_i) * (2*DW)'(data_i);
            qq        <= (2*DW)'(data_q) * (2*DW)'(data_q);
            pwr_valid <= v1;
            pwr_ant   <= a1;
            pwr       <= $unsigned(ii) + $unsigned(qq);
        end
endmodule

// File: rtl/pd_accum.sv
// pd_accum: per-antenna saturating power accumulators with clear and result write port
module pd_accum
    import pd_pkg::*;
#(
    parameter int ANT_NUM = ANT_NUM_D,
    parameter int ANW     = ANW_D,
    parameter int SANW    = SANW_D,
    parameter int DW      = DW_D,
    parameter int ACCW    = ACCW_D
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_valid,
    input  logic [ANW-1:0]       i_ant,
    input  logic signed [DW-1:0] i_data_i,
    input  logic signed [DW-1:0] i_data_q,
    input  logic                 start_clr,
    input  logic                 get_end_wr,
    input  logic [SANW+ANW-1:0]  get_end_addr,
    output logic                 o_wr,
    output logic [SANW+ANW-1:0]  o_addr,
    output logic [ACCW-1:0]      o_data,
    output logic                 o_sat
);
    logic [1:0]      rst_sync;
    logic            rst_n;
    logic            p_valid;
    logic [ANW-1:0]  p_ant;
    logic [2*DW-1:0] p_pwr;
    logic [ACCW-1:0] acc_w [2**ANW];
    logic [2**ANW-1:0] sat_w;
    logic [ANW-1:0]  ra;

    // assert asynchronously, release two clocks after reset rises
    always_ff @(posedge clk or negedge reset)
        if (!reset) rst_sync <= '0;
        else        rst_sync <= {rst_sync[0], 1'b1};

    assign rst_n = rst_sync[1];
    assign ra    = get_end_addr[ANW-1:0];

    pd_pwr #(.ANW(ANW), .DW(DW)) u_pwr (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid     (i_valid),
        .ant       (i_ant),
        .data_i    (i_data_i),
        .data_q    (i_data_q),
        .pwr_valid (p_valid),
        .pwr_ant   (p_ant),
        .pwr       (p_pwr)
    );

    for (genvar g = 0; g < 2**ANW; g++) begin : g_ant
        if (g < ANT_NUM) begin : g_acc
            logic [ACCW-1:0] acc;
            logic            sat;
            logic            hit;
            logic [ACCW:0]   sum;
            assign hit = p_valid && p_ant == ANW'(g);
            assign sum = {1'b0, acc} + {{(ACCW+1-2*DW){1'b0}}, p_pwr};
            // a clear still keeps a sample landing in the same cycle
            always_ff @(posedge clk or negedge rst_n)
                if (!rst_n) begin
                    acc <= '0;
                    sat <= 1'b0;
                end else begin
                    acc <= start_clr ? (hit ? {{(ACCW-2*DW){1'b0}}, p_pwr} : '0)
                         : hit ? (sum[ACCW] ? '1 : sum[ACCW-1:0]) : acc;
                    sat <= !start_clr && (sat || (hit && sum[ACCW]));
                end
            assign acc_w[g] = acc;
            assign sat_w[g] = sat;
        end else begin : g_nil
            assign acc_w[g] = '0;
            assign sat_w[g] = 1'b0;
        end
    end

    // result write reads accumulator state before this cycle's update or clear
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            o_wr   <= 1'b0;
            o_addr <= '0;
            o_data <= '0;
            o_sat  <= 1'b0;
        end else begin
            o_wr <= get_end_wr;
            if (get_end_wr) begin
                o_addr <= get_end_addr;
                o_data <= acc_w[ra];
                o_sat  <= sat_w[ra];
            end
        end
endmodule

// File: tb/tb_pd_accum.sv
// tb_pd_accum: scoreboard bench for pd_accum (default, ACCW=33 and ANT_NUM=3 instances)
module tb_pd_accum;
    typedef struct {
        logic [6:0]  addr;
        logic [47:0] data;
        logic        sat;
    } exp_t;

    logic clk, reset, i_valid, start_clr, get_end_wr;
    logic [2:0] vsel;
    logic [1:0] i_ant;
    logic signed [15:0] i_data_i, i_data_q;
    logic [6:0] get_end_addr;
    logic o_wr, o_sat, s_wr, s_sat, t_wr, t_sat;
    logic [6:0] o_addr, s_addr, t_addr;
    logic [47:0] o_data, t_data;
    logic [32:0] s_data;
    logic [47:0] m_acc [4];
    exp_t q[$];
    exp_t e;
    int checks = 0;
    int failures = 0;

    pd_accum u_dut (
        .clk(clk), .reset(reset), .i_valid(i_valid & vsel[0]), .i_ant(i_ant),
        .i_data_i(i_data_i), .i_data_q(i_data_q), .start_clr(start_clr),
        .get_end_wr(get_end_wr), .get_end_addr(get_end_addr),
        .o_wr(o_wr), .o_addr(o_addr), .o_data(o_data), .o_sat(o_sat)
    );

    pd_accum #(.ACCW(33)) u_sat (
        .clk(clk), .reset(reset), .i_valid(i_valid & vsel[1]), .i_ant(i_ant),
        .i_data_i(i_data_i), .i_data_q(i_data_q), .start_clr(start_clr),
        .get_end_wr(get_end_wr), .get_end_addr(get_end_addr),
        .o_wr(s_wr), .o_addr(s_addr), .o_data(s_data), .o_sat(s_sat)
    );

    pd_accum #(.ANT_NUM(3)) u_a3 (
        .clk(clk), .reset(reset), .i_valid(i_valid & vsel[2]), .i_ant(i_ant),
        .i_data_i(i_data_i), .i_data_q(i_data_q), .start_clr(start_clr),
        .get_end_wr(get_end_wr), .get_end_addr(get_end_addr),
        .o_wr(t_wr), .o_addr(t_addr), .o_data(t_data), .o_sat(t_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard consumer: every write from the default instance pops one expectation
    always @(negedge clk)
        if (o_wr) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected_write got addr=%0h data=%0d sat=%0b exp=no write", o_addr, o_data, o_sat);
            end else begin
                e = q.pop_front();
                if ({o_addr, o_data, o_sat} !== {e.addr, e.data, e.sat}) begin
                    failures++;
                    $display("FAIL sb_write got addr=%0h data=%0d sat=%0b exp addr=%0h data=%0d sat=%0b",
                             o_addr, o_data, o_sat, e.addr, e.data, e.sat);
                end
            end
        end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        repeat (3) tick();
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) m_acc[i] = '0;
    endtask

    task automatic clear();
        start_clr = 1'b1;
        tick();
        start_clr = 1'b0;
        model_clear();
    endtask

    task automatic send(input int ant, input int di, input int dq);
        i_valid  = 1'b1;
        i_ant    = 2'(ant);
        i_data_i = 16'(di);
        i_data_q = 16'(dq);
        if (vsel[0]) m_acc[ant] = m_acc[ant] + 48'(longint'(di) * di + longint'(dq) * dq);
        tick();
        i_valid = 1'b0;
    endtask

    task automatic rd(input logic [6:0] a);
        q.push_back('{addr: a, data: m_acc[a[1:0]], sat: 1'b0});
        get_end_wr   = 1'b1;
        get_end_addr = a;
        tick();
        get_end_wr = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) tick();
        checks++;
        if ({o_wr, o_addr, o_data, o_sat} !== 57'd0) begin
            failures++;
            $display("FAIL reset_outputs got wr=%0b addr=%0h data=%0d sat=%0b exp all 0", o_wr, o_addr, o_data, o_sat);
        end
        checks++;
        if ({s_wr, s_data, t_wr, t_data} !== 83'd0) begin
            failures++;
            $display("FAIL reset_other_dut got s_data=%0d t_data=%0d exp 0", s_data, t_data);
        end
        reset = 1'b1;
        repeat (4) tick();
        rd(7'h02);
    endtask

    task automatic test_basic();
        clear();
        for (int i = 0; i < 10; i++) send(0, 3, 4);
        settle();
        rd(7'h00);
        rd(7'h01);
        send(1, -5, 7);
        send(3, 100, -100);
        send(0, -1, 0);
        settle();
        rd(7'h00);
        rd(7'h01);
        rd(7'h1B);
        checks++;
        if (m_acc[0] !== 48'd251) begin
            failures++;
            $display("FAIL basic_model got=%0d exp=251", m_acc[0]);
        end
    endtask

    task automatic test_saturation();
        vsel = 3'b010;
        clear();
        for (int i = 0; i < 5; i++) send(1, -32768, -32768);
        settle();
        rd(7'h01);
        checks++;
        if ({s_wr, s_addr, s_data, s_sat} !== {1'b1, 7'h01, 33'h1_FFFF_FFFF, 1'b1}) begin
            failures++;
            $display("FAIL sat_readout got wr=%0b addr=%0h data=%0h sat=%0b exp wr=1 addr=1 data=1ffffffff sat=1",
                     s_wr, s_addr, s_data, s_sat);
        end
        clear();
        rd(7'h01);
        checks++;
        if ({s_data, s_sat} !== 34'd0) begin
            failures++;
            $display("FAIL sat_cleared got data=%0h sat=%0b exp data=0 sat=0", s_data, s_sat);
        end
        vsel = 3'b001;
    endtask

    task automatic test_clear_boundary();
        clear();
        send(0, 3, 0);
        send(1, 0, 2);
        send(3, 1, 0);
        settle();
        i_valid  = 1'b1;
        i_ant    = 2'd2;
        i_data_i = 16'sd1;
        i_data_q = 16'sd1;
        tick();
        i_valid = 1'b0;
        tick();
        start_clr = 1'b1;
        tick();
        start_clr = 1'b0;
        model_clear();
        m_acc[2] = 48'd2;
        settle();
        for (int a = 0; a < 4; a++) rd(7'(a));
    endtask

    task automatic test_clear_read();
        clear();
        send(1, 6, 8);
        settle();
        q.push_back('{addr: 7'h01, data: 48'd100, sat: 1'b0});
        start_clr    = 1'b1;
        get_end_wr   = 1'b1;
        get_end_addr = 7'h01;
        tick();
        start_clr  = 1'b0;
        get_end_wr = 1'b0;
        model_clear();
        rd(7'h01);
    endtask

    task automatic test_back_to_back();
        clear();
        send(0, 1, 2);
        send(1, 1, 1);
        send(1, 2, 0);
        send(2, 2, 1);
        send(2, 1, 1);
        send(3, 2, 2);
        settle();
        for (int i = 0; i < 4; i++) begin
            q.push_back('{addr: 7'(8'h14 + i), data: 48'(5 + i), sat: 1'b0});
            get_end_wr   = 1'b1;
            get_end_addr = 7'(8'h14 + i);
            tick();
        end
        get_end_wr = 1'b0;
        tick();
        checks++;
        if ({o_wr, o_addr, o_data} !== {1'b0, 7'h17, 48'd8}) begin
            failures++;
            $display("FAIL b2b_hold got wr=%0b addr=%0h data=%0d exp wr=0 addr=17 data=8", o_wr, o_addr, o_data);
        end
    endtask

    task automatic test_discard();
        vsel = 3'b100;
        clear();
        send(3, 10, 0);
        send(0, 3, 0);
        settle();
        for (int a = 0; a < 4; a++) begin
            rd(7'(a));
            checks++;
            if ({t_wr, t_addr, t_data, t_sat} !== {1'b1, 7'(a), (a == 0) ? 48'd9 : 48'd0, 1'b0}) begin
                failures++;
                $display("FAIL discard_ant%0d got wr=%0b addr=%0h data=%0d sat=%0b exp wr=1 data=%0d sat=0",
                         a, t_wr, t_addr, t_data, t_sat, (a == 0) ? 9 : 0);
            end
        end
        vsel = 3'b001;
    endtask

    task automatic test_reset_mid();
        clear();
        send(0, 10, 0);
        send(3, 3, 0);
        settle();
        rd(7'h00);
        rd(7'h1F);
        send(0, 5, 0);
        reset = 1'b0;
        #1;
        checks++;
        if ({o_wr, o_addr, o_data, o_sat} !== 57'd0) begin
            failures++;
            $display("FAIL reset_mid got wr=%0b addr=%0h data=%0d sat=%0b exp all 0", o_wr, o_addr, o_data, o_sat);
        end
        tick();
        reset = 1'b1;
        model_clear();
        repeat (4) tick();
        rd(7'h00);
        send(0, 2, 0);
        settle();
        rd(7'h00);
        checks++;
        if (o_data !== 48'd4) begin
            failures++;
            $display("FAIL reset_restart got=%0d exp=4", o_data);
        end
    endtask

    initial begin
        i_valid      = 1'b0;
        vsel         = 3'b001;
        i_ant        = '0;
        i_data_i     = '0;
        i_data_q     = '0;
        start_clr    = 1'b0;
        get_end_wr   = 1'b0;
        get_end_addr = '0;
        model_clear();
        test_reset();
        test_basic();
        test_saturation();
        test_clear_boundary();
        test_clear_read();
        test_back_to_back();
        test_discard();
        test_reset_mid();
        repeat (2) tick();
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL sb_missing_writes got pending=%0d exp=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pd_accum.md
PD_ACCUM -- requirements
Module: pd_accum

Interface
REQ-001 Parameter ANT_NUM, default 4, antennas per sample group.
REQ-002 Parameter ANW, default 2, antenna index width; 2**ANW >= ANT_NUM.
REQ-003 Parameter SANW, default 5, subframe address width.
REQ-004 Parameter DW, default 16, signed I/Q sample width.
REQ-005 Parameter ACCW, default 48, accumulator width; ACCW >= 2*DW+1.
REQ-006 clk  in  1  single clock; all logic on rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 i_valid  in  1  sample strobe.
REQ-009 i_ant  in  ANW  antenna index of the current sample.
REQ-010 i_data_i / i_data_q  in  DW each  signed I and Q.
REQ-011 start_clr  in  1  level; clears all accumulators while high (from pd_timer).
REQ-012 get_end_wr  in  1  level; requests a result write per cycle (from pd_timer).
REQ-013 get_end_addr  in  SANW+ANW  result address; low ANW bits select the antenna.
REQ-014 o_wr  out  1  result RAM write enable.
REQ-015 o_addr  out  SANW+ANW  result RAM address.
REQ-016 o_data  out  ACCW  accumulated power.
REQ-017 o_sat  out  1  accumulator saturated since last clear.

Function
REQ-018 Power pipeline stage 1 SHALL register i*i and q*q (signed, 2*DW bits each); stage 2 SHALL register their unsigned sum (2*DW bits, no overflow, max 2**(2*DW-1)).
REQ-019 Stage 3 SHALL add the stage-2 power to acc[ant] (ant delayed with the data); i_valid to accumulator update is 3 cycles.
REQ-020 Addition SHALL saturate at 2**ACCW-1 and set that antenna's sat flag; flag stays set until cleared.
REQ-021 While start_clr is high, every acc and sat flag SHALL be loaded with 0, except an antenna receiving a stage-3 sample that same cycle, which SHALL be loaded with that sample's power (no sample lost at a clear boundary).
REQ-022 i_ant >= ANT_NUM SHALL be discarded without affecting any accumulator.
REQ-023 When get_end_wr is high at cycle N, at cycle N+1: o_wr=1, o_addr=get_end_addr(N), o_data=acc[get_end_addr(N)[ANW-1:0]] value held at end of cycle N-1 (pre-update), o_sat=corresponding flag; otherwise o_wr=0 and o_addr/o_data/o_sat hold.
REQ-024 Consecutive get_end_wr cycles SHALL produce back-to-back writes, one per cycle, no gaps.
REQ-025 get_end_wr and start_clr simultaneously high: the write SHALL report the pre-clear value.
REQ-026 get_end_addr low bits >= ANT_NUM: o_wr=1, o_data=0, o_sat=0.
REQ-027 Pipeline has no backpressure; i_valid accepted every cycle.

Reset
REQ-028 While reset=0: all pipeline valids, acc, sat flags, o_wr, o_addr, o_data, o_sat = 0.
REQ-029 Reset assertion mid-accumulation or mid-write SHALL abort immediately; in-flight samples are dropped; first post-release sample accumulates from 0.
REQ-030 Reset deassertion SHALL be synchronised to clk internally (2-flop) before releasing logic.

Structure
REQ-031 Shared package pd_pkg SHALL hold defaults for ANT_NUM, ANW, SANW, DW, ACCW and the saturation constant, shared with pd_timer instantiations.
REQ-032 One sub-module pd_pwr (2-stage I^2+Q^2 pipeline with ant/valid delay line); accumulators and write port stay in pd_accum.

Verification
REQ-033 Clear, then ant0 samples (I=3,Q=4) x10 -> get_end_wr addr=0x00 -> o_wr=1, o_addr=0x00, o_data=250, o_sat=0 one cycle later.
REQ-034 ant1 (I=-32768,Q=-32768) repeated with ACCW=33 -> acc saturates at 2**33-1, o_sat=1 on readout; start_clr -> next readout 0, o_sat=0.
REQ-035 start_clr high exactly when ant2 sample (I=1,Q=1) reaches stage 3 -> readout ant2 = 2, ants 0/1/3 = 0.
REQ-036 get_end_wr high 4 cycles, addr 0x14..0x17, acc = {5,6,7,8} -> 4 back-to-back writes, o_data 5,6,7,8, addresses match.
REQ-037 i_ant=3 with ANT_NUM=3, sample (I=10,Q=0) -> all readouts 0; readout addr low bits=3 -> o_data=0.
REQ-038 reset=0 for 1 cycle mid-stream (acc0=100) -> all outputs 0; after release, sample (I=2,Q=0) -> readout 4.
